// File: rtl/cypher_collector.sv
// cypher_collector: steps the mux select through 0..3, packs the captured nibbles
// into a 16-bit word and offers it on a valid/ready handshake.
module cypher_collector #(
  parameter logic [3:0] XOR_KEY   = 4'h0,
  parameter bit         LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [1:0]  s,
  input  logic [3:0]  cypher,
  output logic        busy,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready
);
  typedef enum logic [1:0] {IDLE, CAPTURE, OUT} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [15:0] word_n;
  logic [3:0] pos;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      word  <= 16'h0000;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      word  <= word_n;
    end
  always_comb begin
    state_n = state;
    idx_n   = idx;
    word_n  = word;
    pos     = LSB_FIRST ? {idx, 2'b00} : 4'd12 - {idx, 2'b00};
    case (state)
      IDLE: begin
        state_n = start ? CAPTURE : IDLE;
        idx_n   = 2'd0;
      end
      CAPTURE: begin
        word_n[pos +: 4] = cypher ^ XOR_KEY;
        idx_n   = idx + 2'd1;
        state_n = (idx == 2'd3) ? OUT : CAPTURE;
      end
      OUT: begin
        state_n = word_ready ? (start ? CAPTURE : IDLE) : OUT;
        idx_n   = 2'd0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = 2'd0;
      end
    endcase
  end
  // idx is zero outside CAPTURE, so the registered select is idx itself
  assign s          = idx;
  assign busy       = state != IDLE;
  assign word_valid = state == OUT;
endmodule

// File: tb/tb_cypher_collector.sv
// tb_cypher_collector: directed checks of two collector configurations against a
// modelled 4:1 mux, with expected words queued at start and popped at valid.
module tb_cypher_collector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic word_ready = 1'b0;
  logic [1:0] s, s2;
  logic [3:0] cypher, cypher2;
  logic busy, busy2, word_valid, word_valid2;
  logic [15:0] word, word2;
  logic [3:0] vals [4];
  logic [15:0] q [$];
  logic [15:0] q2 [$];
  int vecs = 0;
  int errs = 0;
  int n;

  always #5 clk = ~clk;
  assign cypher  = vals[s];
  assign cypher2 = vals[s2];

  cypher_collector dut (
    .clk(clk), .rst(rst), .start(start), .s(s), .cypher(cypher), .busy(busy),
    .word(word), .word_valid(word_valid), .word_ready(word_ready)
  );

  cypher_collector #(.XOR_KEY(4'hF), .LSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .s(s2), .cypher(cypher2), .busy(busy2),
    .word(word2), .word_valid(word_valid2), .word_ready(word_ready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!word_valid && cnt < 20);
  endtask

  task automatic check_pop(input string tag);
    logic [15:0] e, e2;
    e  = (q.size()  > 0) ? q.pop_front()  : 16'hxxxx;
    e2 = (q2.size() > 0) ? q2.pop_front() : 16'hxxxx;
    chk({tag, "_word"}, word, e);
    chk({tag, "_word2"}, word2, e2);
    chk({tag, "_valid"}, {15'd0, word_valid}, 16'd1);
    chk({tag, "_valid2"}, {15'd0, word_valid2}, 16'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s"}, {14'd0, s}, 16'd0);
    chk({tag, "_word"}, word, 16'h0000);
    chk({tag, "_word2"}, word2, 16'h0000);
    chk({tag, "_valid"}, {15'd0, word_valid}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    vals = '{4'h1, 4'h2, 4'h3, 4'h4};
    // asynchronous reset with no clock edge in between
    #3 rst = 1'b1;
    #1 check_reset("rst_async");
    cyc();
    rst = 1'b0;
    cyc();

    // basic collect
    start = 1'b1;
    q.push_back(16'h4321);
    q2.push_back(16'hEDCB);
    cyc();
    start = 1'b0;
    chk("basic_s0", {14'd0, s}, 16'd0);
    chk("basic_busy", {15'd0, busy}, 16'd1);
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("basic_s_seq", {14'd0, s}, 16'(k));
    end
    chk("basic_not_valid_yet", {15'd0, word_valid}, 16'd0);
    cyc();
    check_pop("basic");
    chk("basic_out_s", {14'd0, s}, 16'd0);

    // backpressure: start ignored while word_ready is low
    for (int k = 0; k < 3; k++) begin
      start = k[0] ? 1'b0 : 1'b1;
      cyc();
      chk("bp_valid", {15'd0, word_valid}, 16'd1);
      chk("bp_word", word, 16'h4321);
      chk("bp_s", {14'd0, s}, 16'd0);
    end
    start = 1'b0;
    word_ready = 1'b1;
    cyc();
    chk("bp_idle_valid", {15'd0, word_valid}, 16'd0);
    chk("bp_idle_busy", {15'd0, busy}, 16'd0);
    chk("bp_idle_word_kept", word, 16'h4321);

    // back-to-back with start and word_ready held high
    start = 1'b1;
    q.push_back(16'h4321);
    q2.push_back(16'hEDCB);
    wait_valid(n);
    chk("b2b_first_latency", 16'(n), 16'd5);
    check_pop("b2b_first");
    vals = '{4'hA, 4'hB, 4'hC, 4'hD};
    q.push_back(16'hDCBA);
    q2.push_back(16'h5432);
    wait_valid(n);
    chk("b2b_second_latency", 16'(n), 16'd5);
    check_pop("b2b_second");
    start = 1'b0;
    cyc();
    chk("b2b_idle_busy", {15'd0, busy}, 16'd0);
    word_ready = 1'b0;

    // reset in the middle of a capture
    vals = '{4'h5, 4'h6, 4'h7, 4'h8};
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    cyc();
    rst = 1'b0;
    cyc();
    check_reset("rst_hold");
    vals = '{4'h7, 4'h0, 4'hE, 4'h9};
    start = 1'b1;
    q.push_back(16'h9E07);
    q2.push_back(16'h8F16);
    cyc();
    start = 1'b0;
    n = 1;
    if (!word_valid) begin
      int m;
      wait_valid(m);
      n += m;
    end
    chk("fresh_latency", 16'(n), 16'd5);
    check_pop("fresh");
    chk("queue_drained", 16'(q.size() + q2.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
